sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter N_SPR, default 4, number of sprite channels (1..8); channel 0 is the hero.
REQ-002 Parameter SPR_W, default 32, sprite width in pixels.
REQ-003 Parameter SPR_H, default 32, sprite height in pixels.
REQ-004 Port pclk  in  1  pixel clock; the only clock; all logic is on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-low reset.
REQ-006 Ports hcount_in, vcount_in  in  11 each  pixel position; hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each; rgb_in  in  12  upstream pixel.
REQ-007 Port spr_x, spr_y  in  N_SPR*12 each  top-left corner of each sprite; channel k occupies bits [12k+11:12k].
REQ-008 Port spr_rgb  in  N_SPR*12  solid colour per sprite; spr_en  in  N_SPR  draw enable per sprite.
REQ-009 Ports hcount_out, vcount_out  out  11; hsync_out, vsync_out, hblnk_out, vblnk_out  out  1; rgb_out  out  12.
REQ-010 Port coll  out  N_SPR-1  per-frame hero overlap flags for channels 1..N_SPR-1; coll_valid  out  1  one-cycle pulse when coll updates.

Function
REQ-011 Sprite inputs SHALL be sampled into shadow registers only on the cycle vblnk_in rises (0->1); drawing SHALL use shadow values only, so mid-frame input changes cannot tear the image.
REQ-012 Channel k SHALL be hit when shadow en[k]=1, hcount_in >= x[k], hcount_in < x[k]+SPR_W, vcount_in >= y[k], vcount_in < y[k]+SPR_H; the sums SHALL be computed 13 bits wide, so they never wrap and sprites past the screen edge are clipped.
REQ-013 Pipeline depth SHALL be exactly 2 cycles: stage 1 registers per-channel hit bits and the delayed timing/rgb; stage 2 registers the composited pixel.
REQ-014 Priority: the lowest-index hit channel SHALL win (hero on top); with no hit, rgb_out SHALL equal rgb_in delayed 2 cycles.
REQ-015 rgb_out SHALL be 12'h000 whenever the stage-2 hblnk or vblnk is 1.
REQ-016 All timing outputs SHALL equal their inputs delayed exactly 2 cycles, unchanged.
REQ-017 Collision accumulator bit k-1 SHALL be set sticky in stage 1 when channels 0 and k are both hit on the same active pixel.
REQ-018 On the cycle vblnk_in rises, coll SHALL load the accumulator, coll_valid SHALL pulse high for 1 cycle, and the accumulator SHALL clear. A hit on that same cycle SHALL go into the new frame's accumulator.
REQ-019 A disabled sprite (shadow en=0) SHALL neither draw nor collide.

Reset
REQ-020 While rst=0 at a clock edge: shadow registers, accumulator, coll and coll_valid clear to 0; pipeline timing and rgb registers clear to 0.
REQ-021 After reset deasserts mid-frame, no sprite SHALL draw until the next vblnk rise latches the inputs.

Configuration
REQ-022 Macro SPRITE_COMPOSITOR_COLLISION_EN: when defined, REQ-017/018 logic is present.
REQ-023 When the macro is undefined, coll and coll_valid SHALL be tied to 0, no accumulator SHALL be built, and compositing SHALL be unchanged.

Structure
REQ-024 Package sprite_pkg SHALL hold COORD_W=12, CNT_W=11, RGB_W=12, BLACK=12'h000 and the 2-cycle latency constant PIPE_LAT.
REQ-025 Sub-module sprite_hit (one per channel, generate loop) SHALL hold the REQ-012 comparator and its stage-1 hit register.

Verification
REQ-026 Sprite 0 at (100,200), rgb 12'hF00, en=1, latched at vblnk -> rgb_out=F00 for hcount 100..131 and vcount 200..231, sampled 2 cycles after the input pixel; rgb_in elsewhere.
REQ-027 Sprites 0 and 2 overlapping at (300,300) and (310,310) -> overlap pixels show sprite 0 colour; after the next vblnk rise coll=3'b010 and coll_valid pulses 1 cycle.
REQ-028 spr_x[0] changed from 100 to 400 at vcount 384 -> rest of the frame still at 100; next frame at 400.
REQ-029 Sprite at x=1010 -> drawn at hcount 1010..1023 only; no wrap at hcount 0..9.
REQ-030 rst=0 for one cycle mid-frame -> all outputs 0 on the next cycle; no sprite drawn until the next vblnk rise; with the macro undefined, coll stays 0 under the REQ-027 stimulus.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared widths, colours and pipeline constants for the sprite compositor.
package sprite_pkg;
    localparam int COORD_W  = 12;
    localparam int CNT_W    = 11;
    localparam int RGB_W    = 12;
    localparam int PIPE_LAT = 2;
    localparam logic [RGB_W-1:0] BLACK = 12'h000;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } timing_t;
endpackage

// File: rtl/sprite_hit.sv
// Per-channel rectangle test against the current pixel, plus its stage-1 hit register.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32
) (
    input  logic               i_pclk,
    input  logic               i_rst_n,
    input  logic [CNT_W-1:0]   i_hcount,
    input  logic [CNT_W-1:0]   i_vcount,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_en,
    output logic               o_hit_now,
    output logic               o_hit
);
    // One extra bit so x+SPR_W near the top of the coordinate range clips instead of wrapping.
    localparam int SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] w_h, w_v, w_x0, w_y0, w_x1, w_y1;
    logic             r_hit;

    assign w_h  = SUM_W'(i_hcount);
    assign w_v  = SUM_W'(i_vcount);
    assign w_x0 = SUM_W'(i_x);
    assign w_y0 = SUM_W'(i_y);
    assign w_x1 = w_x0 + SUM_W'(SPR_W);
    assign w_y1 = w_y0 + SUM_W'(SPR_H);

    assign o_hit_now = i_en && (w_h >= w_x0) && (w_h < w_x1) && (w_v >= w_y0) && (w_v < w_y1);
    assign o_hit     = r_hit;

    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) r_hit <= 1'b0;
        else          r_hit <= o_hit_now;
    end
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite overlay on a video stream; hero (channel 0) draws on top.
// Hero collision flags are built only when SPRITE_COMPOSITOR_COLLISION_EN is defined.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int N_SPR = 4,
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    localparam int COLL_W = (N_SPR > 1) ? N_SPR - 1 : 1
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         hcount_in,
    input  logic [CNT_W-1:0]         vcount_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     hblnk_in,
    input  logic                     vblnk_in,
    input  logic [RGB_W-1:0]         rgb_in,
    input  logic [N_SPR*COORD_W-1:0] spr_x,
    input  logic [N_SPR*COORD_W-1:0] spr_y,
    input  logic [N_SPR*RGB_W-1:0]   spr_rgb,
    input  logic [N_SPR-1:0]         spr_en,
    output logic [CNT_W-1:0]         hcount_out,
    output logic [CNT_W-1:0]         vcount_out,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     hblnk_out,
    output logic                     vblnk_out,
    output logic [RGB_W-1:0]         rgb_out,
    output logic [COLL_W-1:0]        coll,
    output logic                     coll_valid
);
    logic                              r_vb_d;
    logic                              w_vrise;
    logic [N_SPR-1:0][COORD_W-1:0]     r_sx, r_sy;
    logic [N_SPR-1:0][RGB_W-1:0]       r_srgb;
    logic [N_SPR-1:0]                  r_sen;
    logic [N_SPR-1:0]                  w_hit_now, r_hit;
    timing_t                           w_tim_in;
    timing_t [PIPE_LAT-1:0]            r_tim;
    logic [RGB_W-1:0]                  r_rgb1, r_rgb2, w_pix;

    assign w_vrise = vblnk_in & ~r_vb_d;

    // Sprite attributes only move at the start of vertical blank, so a frame never tears.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_vb_d <= 1'b0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_srgb <= '0;
            r_sen  <= '0;
        end else begin
            r_vb_d <= vblnk_in;
            if (w_vrise) begin
                r_sx   <= spr_x;
                r_sy   <= spr_y;
                r_srgb <= spr_rgb;
                r_sen  <= spr_en;
            end
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_hit
        sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
            .i_pclk    (pclk),
            .i_rst_n   (rst),
            .i_hcount  (hcount_in),
            .i_vcount  (vcount_in),
            .i_x       (r_sx[g]),
            .i_y       (r_sy[g]),
            .i_en      (r_sen[g]),
            .o_hit_now (w_hit_now[g]),
            .o_hit     (r_hit[g])
        );
    end

    assign w_tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    always_comb begin
        w_pix = r_rgb1;
        for (int k = N_SPR - 1; k >= 0; k--)
            if (r_hit[k]) w_pix = r_srgb[k];
        if (r_tim[0].hblnk || r_tim[0].vblnk) w_pix = BLACK;
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_tim  <= '0;
            r_rgb1 <= '0;
            r_rgb2 <= '0;
        end else begin
            r_tim  <= {r_tim[PIPE_LAT-2:0], w_tim_in};
            r_rgb1 <= rgb_in;
            r_rgb2 <= w_pix;
        end
    end

    assign hcount_out = r_tim[PIPE_LAT-1].hcount;
    assign vcount_out = r_tim[PIPE_LAT-1].vcount;
    assign hsync_out  = r_tim[PIPE_LAT-1].hsync;
    assign vsync_out  = r_tim[PIPE_LAT-1].vsync;
    assign hblnk_out  = r_tim[PIPE_LAT-1].hblnk;
    assign vblnk_out  = r_tim[PIPE_LAT-1].vblnk;
    assign rgb_out    = r_rgb2;

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    logic [COLL_W-1:0] r_acc, r_coll, w_coll_now;
    logic              r_coll_vld;

    always_comb begin
        w_coll_now = '0;
        for (int k = 1; k < N_SPR; k++)
            w_coll_now[k-1] = w_hit_now[0] & w_hit_now[k] & ~hblnk_in & ~vblnk_in;
    end

    // The frame boundary hands the finished accumulator to coll; this cycle's hits start the next one.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_acc      <= '0;
            r_coll     <= '0;
            r_coll_vld <= 1'b0;
        end else if (w_vrise) begin
            r_coll     <= r_acc;
            r_acc      <= w_coll_now;
            r_coll_vld <= 1'b1;
        end else begin
            r_acc      <= r_acc | w_coll_now;
            r_coll_vld <= 1'b0;
        end
    end

    assign coll       = r_coll;
    assign coll_valid = r_coll_vld;
`else
    logic w_unused_hit;
    assign w_unused_hit = ^w_hit_now;
    assign coll         = '0;
    assign coll_valid   = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a per-cycle reference model and literal probes.
module tb_sprite_compositor;
    localparam int N = 4;
    localparam int W = 32;
    localparam int H = 32;
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    localparam bit COLL_ON = 1'b1;
`else
    localparam bit COLL_ON = 1'b0;
`endif

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    always #5 pclk = ~pclk;

    logic [10:0]     hcount_in, vcount_in;
    logic            hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0]     rgb_in;
    logic [N*12-1:0] spr_x, spr_y, spr_rgb;
    logic [N-1:0]    spr_en;
    logic [10:0]     hcount_out, vcount_out;
    logic            hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0]     rgb_out;
    logic [N-2:0]    coll;
    logic            coll_valid;

    sprite_compositor #(.N_SPR(N), .SPR_W(W), .SPR_H(H)) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .spr_x(spr_x), .spr_y(spr_y), .spr_rgb(spr_rgb), .spr_en(spr_en),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .coll(coll), .coll_valid(coll_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int h; int v; bit hs; bit vs; bit hb; bit vb; int rgb; } exp_t;
    exp_t q[$];
    int   mx[N], my[N], mrgb[N];
    bit   men[N];
    bit   prev_vb;
    int   acc, coll_m;
    bit   cv_m;
    int   cyc = 0;

    function automatic bit mhit(int k, int h, int v);
        return men[k] && h >= mx[k] && h < mx[k] + W && v >= my[k] && v < my[k] + H;
    endfunction

    always @(negedge pclk) begin
        exp_t e, z;
        int   now;
        bit   rise;
        cyc++;
        z = '{default: 0};
        if (q.size() == 2) begin
            e = q.pop_front();
            chk($sformatf("rgb_out@%0d", cyc), rgb_out, e.rgb);
            chk($sformatf("timing@%0d", cyc),
                {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
                {11'(e.h), 11'(e.v), e.hs, e.vs, e.hb, e.vb});
        end
        if (cyc > 1) chk($sformatf("coll@%0d", cyc), {coll_valid, coll}, {cv_m, 3'(coll_m)});
        if (!rst) begin
            if (q.size() > 0) q[q.size()-1] = z;
            q.push_back(z);
            for (int k = 0; k < N; k++) begin mx[k] = 0; my[k] = 0; mrgb[k] = 0; men[k] = 0; end
            prev_vb = 0; acc = 0; coll_m = 0; cv_m = 0;
        end else begin
            e.h = hcount_in; e.v = vcount_in; e.hs = hsync_in; e.vs = vsync_in;
            e.hb = hblnk_in; e.vb = vblnk_in; e.rgb = rgb_in;
            if (hblnk_in || vblnk_in) e.rgb = 0;
            else
                for (int k = N - 1; k >= 0; k--)
                    if (mhit(k, e.h, e.v)) e.rgb = mrgb[k];
            q.push_back(e);
            now = 0;
            if (!hblnk_in && !vblnk_in && mhit(0, e.h, e.v))
                for (int k = 1; k < N; k++)
                    if (mhit(k, e.h, e.v)) now |= 1 << (k - 1);
            rise = vblnk_in && !prev_vb;
            if (COLL_ON && rise) begin coll_m = acc; cv_m = 1; acc = now; end
            else if (COLL_ON)    begin acc |= now; cv_m = 0; end
            if (rise)
                for (int k = 0; k < N; k++) begin
                    mx[k] = spr_x[12*k +: 12]; my[k] = spr_y[12*k +: 12];
                    mrgb[k] = spr_rgb[12*k +: 12]; men[k] = spr_en[k];
                end
            prev_vb = vblnk_in;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [11:0] pat(int h, int v);
        return 12'((h * 7 + v * 13) ^ 'h3C3);
    endfunction

    task automatic pix(input int h, input int v, input logic [11:0] c, input bit hb = 0, input bit vb = 0);
        @(posedge pclk); #1;
        hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = c;
        hsync_in = (h % 7 == 0); vsync_in = (v % 5 == 0);
        hblnk_in = hb; vblnk_in = vb;
    endtask

    task automatic probe(input string name, input int h, input int v, input logic [11:0] c,
                         input logic [11:0] exp, input bit hb = 0);
        pix(h, v, c, hb, 0);
        pix(0, 0, 12'h0, 1, 0);
        pix(0, 0, 12'h0, 1, 0);
        @(negedge pclk);
        chk(name, rgb_out, exp);
    endtask

    task automatic scan(input int v0, input int v1, input int h0, input int h1);
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++) pix(h, v, pat(h, v));
    endtask

    task automatic set_spr(input int k, input int x, input int y, input logic [11:0] c, input bit en);
        spr_x[12*k +: 12] = 12'(x); spr_y[12*k +: 12] = 12'(y);
        spr_rgb[12*k +: 12] = c;    spr_en[k] = en;
    endtask

    task automatic vrise(input string name, input logic [2:0] exp_coll);
        pix(0, 0, 12'h0, 1, 0);
        pix(0, 0, 12'h0, 1, 1);
        @(posedge pclk); @(negedge pclk);
        chk({name, " coll"}, {coll_valid, coll}, {COLL_ON, COLL_ON ? exp_coll : 3'b000});
        @(negedge pclk);
        chk({name, " pulse end"}, coll_valid, 1'b0);
        pix(0, 0, 12'h0, 1, 0);
    endtask

    initial begin
        hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
        hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
        spr_x = '0; spr_y = '0; spr_rgb = '0; spr_en = '0;
        repeat (3) @(posedge pclk);
        #1 rst = 1'b1;
        @(negedge pclk);
        chk("reset rgb", rgb_out, 12'h000);
        chk("reset timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
        chk("reset coll", {coll_valid, coll}, 0);

        // Single hero sprite, inputs not yet latched
        set_spr(0, 100, 200, 12'hF00, 1);
        probe("pre-latch", 100, 200, 12'h123, 12'h123);
        vrise("frame1", 3'b000);
        probe("s0 top-left", 100, 200, 12'h123, 12'hF00);
        probe("s0 bottom-right", 131, 231, 12'h456, 12'hF00);
        probe("s0 right edge", 132, 231, 12'h456, 12'h456);
        probe("s0 below", 100, 232, 12'h789, 12'h789);
        probe("s0 left", 99, 200, 12'hABC, 12'hABC);
        probe("hblank black", 110, 210, 12'h777, 12'h000, 1);
        scan(198, 233, 96, 135);

        // Overlap: hero vs channel 2; channels 1 and 3 disabled
        set_spr(0, 300, 300, 12'hF00, 1);
        set_spr(1, 340, 340, 12'h00F, 0);
        set_spr(2, 310, 310, 12'h0F0, 1);
        set_spr(3, 300, 300, 12'hFFF, 0);
        vrise("frame2", 3'b000);
        probe("overlap hero wins", 315, 315, 12'h111, 12'hF00);
        probe("s2 alone", 335, 335, 12'h111, 12'h0F0);
        probe("disabled s1", 345, 345, 12'h222, 12'h222);
        scan(305, 320, 305, 320);
        scan(328, 346, 328, 346);
        vrise("frame3", 3'b010);
        vrise("frame4", 3'b000);

        // Mid-frame position change must wait for the next vblank
        set_spr(1, 0, 0, 12'h0, 0);
        set_spr(2, 0, 0, 12'h0, 0);
        set_spr(0, 100, 380, 12'hF00, 1);
        vrise("frame5", 3'b000);
        probe("old pos", 105, 384, 12'h345, 12'hF00);
        set_spr(0, 400, 380, 12'hF00, 1);
        probe("mid-frame old pos", 105, 384, 12'h345, 12'hF00);
        probe("mid-frame new pos", 405, 384, 12'h345, 12'h345);
        scan(384, 384, 95, 140);
        scan(384, 384, 395, 440);
        vrise("frame6", 3'b000);
        probe("next frame new", 405, 384, 12'h345, 12'hF00);
        probe("next frame old", 105, 384, 12'h345, 12'h345);

        // Right-edge clipping
        set_spr(0, 1010, 10, 12'hF00, 1);
        vrise("frame7", 3'b000);
        probe("clip left edge", 1010, 10, 12'h0AA, 12'hF00);
        probe("clip last col", 1023, 10, 12'h0AA, 12'hF00);
        probe("clip before", 1009, 10, 12'h0AA, 12'h0AA);
        probe("no wrap h0", 0, 10, 12'h0AA, 12'h0AA);
        probe("no wrap h9", 9, 10, 12'h0AA, 12'h0AA);
        scan(8, 12, 1000, 1023);
        scan(8, 12, 0, 12);

        // Mid-frame reset
        set_spr(0, 100, 200, 12'hF00, 1);
        vrise("frame8", 3'b000);
        probe("before reset", 100, 200, 12'h321, 12'hF00);
        @(posedge pclk); #1;
        rst = 1'b0; hcount_in = 11'd100; vcount_in = 11'd200; hsync_in = 1; vsync_in = 1;
        rgb_in = 12'h321; hblnk_in = 0; vblnk_in = 0;
        @(posedge pclk); #1 rst = 1'b1;
        @(negedge pclk);
        chk("post-reset rgb", rgb_out, 12'h000);
        chk("post-reset timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
        chk("post-reset coll", {coll_valid, coll}, 0);
        probe("no draw after reset", 100, 200, 12'h321, 12'h321);
        scan(200, 202, 98, 104);
        vrise("frame9", 3'b000);
        probe("relatched", 100, 200, 12'h321, 12'hF00);

        // Collision stimulus again after reset
        set_spr(0, 300, 300, 12'hF00, 1);
        set_spr(2, 310, 310, 12'h0F0, 1);
        vrise("frame10", 3'b000);
        scan(310, 312, 310, 314);
        vrise("frame11", 3'b010);

        repeat (4) pix(0, 0, 12'h0, 1, 0);
        @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
